// File: rtl/dbg_axi_pkg.sv
// Shared types and beat-address helpers for the debug AXI slave and master-side models.
// Optional WRAP burst support is enabled with `define DBG_AXI_SLAVE_WRAP_EN.
package dbg_axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_DATA,
    ST_WR_RESP,
    ST_RD_FETCH,
    ST_RD_DATA
  } slave_state_e;

  typedef struct packed {
    logic [7:0] len;
    logic [2:0] size;
    burst_e     burst;
  } burst_cfg_t;

  // Address of the beat following addr; WRAP folds back inside a (len+1)<<size window.
  function automatic logic [63:0] next_beat_addr(input logic [63:0] addr, input logic [2:0] size,
                                                 input logic [7:0] len, input burst_e burst);
    logic [63:0] step;
    logic [63:0] mask;
    step = 64'(1) << size;
    mask = ((64'(len) + 64'd1) << size) - 64'd1;
    case (burst)
      BURST_FIXED: next_beat_addr = addr;
      BURST_WRAP:  next_beat_addr = (addr & ~mask) | ((addr + step) & mask);
      default:     next_beat_addr = addr + step;
    endcase
  endfunction

  // Whole-burst legality: supported size and burst type, plus WRAP length/alignment rules.
  function automatic logic burst_legal(input burst_cfg_t cfg, input logic [2:0] addr_lo);
    logic [7:0] align_mask;
    align_mask  = (8'd1 << cfg.size) - 8'd1;
    burst_legal = (cfg.size <= 3'd3);
    case (cfg.burst)
      BURST_FIXED, BURST_INCR: ;
`ifdef DBG_AXI_SLAVE_WRAP_EN
      BURST_WRAP: burst_legal = burst_legal &&
                                (cfg.len == 8'd1 || cfg.len == 8'd3 || cfg.len == 8'd7 || cfg.len == 8'd15) &&
                                ((8'(addr_lo) & align_mask) == 8'd0);
`endif
      default: burst_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dbg_axi_slave_ram.sv
// Single-port byte-enable RAM with registered read; written to infer block RAM.
module dbg_axi_slave_ram #(
  parameter int unsigned DEPTH  = 2048,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                en,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  input  logic [IDX_W-1:0]    idx,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata
);

  localparam int unsigned STRB_W = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int unsigned i = 0; i < STRB_W; i++) begin
          if (be[i]) mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/dbg_axi_slave_mem.sv
// AXI4 slave backed by on-chip RAM; serves one write or read burst at a time.
// WRAP bursts are accepted only when DBG_AXI_SLAVE_WRAP_EN is defined.
module dbg_axi_slave_mem
  import dbg_axi_pkg::*;
#(
  parameter int unsigned               AXI_ADDR_WIDTH = 32,
  parameter int unsigned               AXI_DATA_WIDTH = 64,
  parameter int unsigned               AXI_ID_WIDTH   = 4,
  parameter int unsigned               MEM_DEPTH      = 2048,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        aw_valid,
  output logic                        aw_ready,
  input  logic [AXI_ADDR_WIDTH-1:0]   aw_addr,
  input  logic [7:0]                  aw_len,
  input  logic [2:0]                  aw_size,
  input  logic [1:0]                  aw_burst,
  input  logic [AXI_ID_WIDTH-1:0]     aw_id,
  input  logic                        w_valid,
  output logic                        w_ready,
  input  logic [AXI_DATA_WIDTH-1:0]   w_data,
  input  logic [AXI_DATA_WIDTH/8-1:0] w_strb,
  input  logic                        w_last,
  output logic                        b_valid,
  input  logic                        b_ready,
  output logic [1:0]                  b_resp,
  output logic [AXI_ID_WIDTH-1:0]     b_id,
  input  logic                        ar_valid,
  output logic                        ar_ready,
  input  logic [AXI_ADDR_WIDTH-1:0]   ar_addr,
  input  logic [7:0]                  ar_len,
  input  logic [2:0]                  ar_size,
  input  logic [1:0]                  ar_burst,
  input  logic [AXI_ID_WIDTH-1:0]     ar_id,
  output logic                        r_valid,
  input  logic                        r_ready,
  output logic [AXI_DATA_WIDTH-1:0]   r_data,
  output logic [1:0]                  r_resp,
  output logic                        r_last,
  output logic [AXI_ID_WIDTH-1:0]     r_id
);

  localparam int unsigned IDX_W      = $clog2(MEM_DEPTH);
  localparam int unsigned STRB_W     = AXI_DATA_WIDTH / 8;
  localparam int unsigned LANE_SHIFT = $clog2(STRB_W);

  slave_state_e              state_q, state_d;
  logic                      rr_wr_q, rr_wr_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  burst_cfg_t                cfg_q, cfg_d;
  logic [AXI_ID_WIDTH-1:0]   id_q, id_d;
  logic [7:0]                beats_q, beats_d;
  logic                      bad_q, bad_d;
  logic                      werr_q, werr_d;
  logic                      r_ok_q, r_ok_d;
  logic                      w_ready_d, b_valid_d, r_valid_d, r_last_d;
  logic [1:0]                b_resp_d, r_resp_d;
  logic [AXI_ID_WIDTH-1:0]   b_id_d, r_id_d;

  burst_cfg_t                aw_cfg, ar_cfg;
  logic                      grant_w, grant_r, in_range, beat_ok, w_hs, beat_err;
  logic [AXI_ADDR_WIDTH-1:0] off, addr_nx;

  logic                      ram_en, ram_we;
  logic [IDX_W-1:0]          ram_idx;
  logic [AXI_DATA_WIDTH-1:0] ram_rdata;

  // Round-robin grant in IDLE; rr_wr_q set means the write channel wins a tie.
  assign grant_w  = (state_q == ST_IDLE) && aw_valid && (rr_wr_q || !ar_valid);
  assign grant_r  = (state_q == ST_IDLE) && ar_valid && (!rr_wr_q || !aw_valid);
  assign aw_ready = grant_w;
  assign ar_ready = grant_r;

  assign aw_cfg = '{len: aw_len, size: aw_size, burst: burst_e'(aw_burst)};
  assign ar_cfg = '{len: ar_len, size: ar_size, burst: burst_e'(ar_burst)};

  assign off      = addr_q - BASE_ADDR;
  assign in_range = (addr_q >= BASE_ADDR) && ((off >> LANE_SHIFT) < AXI_ADDR_WIDTH'(MEM_DEPTH));
  assign beat_ok  = in_range && !bad_q;
  assign addr_nx  = AXI_ADDR_WIDTH'(next_beat_addr(64'(addr_q), cfg_q.size, cfg_q.len, cfg_q.burst));
  assign w_hs     = w_valid && w_ready;

  assign ram_en  = w_hs || (state_q == ST_RD_FETCH);
  assign ram_we  = w_hs && beat_ok;
  assign ram_idx = IDX_W'(off >> LANE_SHIFT);

  // Read data is zeroed for out-of-range or illegal beats without touching the RAM output register.
  assign r_data = r_ok_q ? ram_rdata : '0;

  dbg_axi_slave_ram #(
    .DEPTH (MEM_DEPTH),
    .DATA_W(AXI_DATA_WIDTH),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we),
    .be   (w_strb),
    .idx  (ram_idx),
    .wdata(w_data),
    .rdata(ram_rdata)
  );

  always_comb begin
    state_d   = state_q;
    rr_wr_d   = rr_wr_q;
    addr_d    = addr_q;
    cfg_d     = cfg_q;
    id_d      = id_q;
    beats_d   = beats_q;
    bad_d     = bad_q;
    werr_d    = werr_q;
    r_ok_d    = r_ok_q;
    b_valid_d = b_valid;
    b_resp_d  = b_resp;
    b_id_d    = b_id;
    r_valid_d = r_valid;
    r_resp_d  = r_resp;
    r_last_d  = r_last;
    r_id_d    = r_id;
    beat_err  = !beat_ok || (w_last != (beats_q == 8'd0));

    unique case (state_q)
      ST_IDLE: begin
        if (grant_w) begin
          addr_d  = aw_addr;
          cfg_d   = aw_cfg;
          id_d    = aw_id;
          beats_d = aw_len;
          bad_d   = !burst_legal(aw_cfg, aw_addr[2:0]);
          werr_d  = 1'b0;
          rr_wr_d = 1'b0;
          state_d = ST_WR_DATA;
        end else if (grant_r) begin
          addr_d  = ar_addr;
          cfg_d   = ar_cfg;
          id_d    = ar_id;
          beats_d = ar_len;
          bad_d   = !burst_legal(ar_cfg, ar_addr[2:0]);
          rr_wr_d = 1'b1;
          state_d = ST_RD_FETCH;
        end
      end
      ST_WR_DATA: begin
        if (w_hs) begin
          werr_d  = werr_q || beat_err;
          addr_d  = addr_nx;
          beats_d = beats_q - 8'd1;
          // Burst length is set by aw_len; w_last only contributes to the response.
          if (beats_q == 8'd0) begin
            state_d   = ST_WR_RESP;
            b_valid_d = 1'b1;
            b_id_d    = id_q;
            b_resp_d  = (werr_q || beat_err) ? RESP_SLVERR : RESP_OKAY;
          end
        end
      end
      ST_WR_RESP: begin
        if (b_ready) begin
          b_valid_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      ST_RD_FETCH: begin
        r_valid_d = 1'b1;
        r_id_d    = id_q;
        r_resp_d  = beat_ok ? RESP_OKAY : RESP_SLVERR;
        r_last_d  = (beats_q == 8'd0);
        r_ok_d    = beat_ok;
        state_d   = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        if (r_ready) begin
          r_valid_d = 1'b0;
          r_last_d  = 1'b0;
          r_ok_d    = 1'b0;
          if (r_last) begin
            state_d = ST_IDLE;
          end else begin
            addr_d  = addr_nx;
            beats_d = beats_q - 8'd1;
            state_d = ST_RD_FETCH;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    w_ready_d = (state_d == ST_WR_DATA);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rr_wr_q <= 1'b1;
      addr_q  <= '0;
      cfg_q   <= '0;
      id_q    <= '0;
      beats_q <= '0;
      bad_q   <= 1'b0;
      werr_q  <= 1'b0;
      r_ok_q  <= 1'b0;
      w_ready <= 1'b0;
      b_valid <= 1'b0;
      b_resp  <= '0;
      b_id    <= '0;
      r_valid <= 1'b0;
      r_resp  <= '0;
      r_last  <= 1'b0;
      r_id    <= '0;
    end else begin
      state_q <= state_d;
      rr_wr_q <= rr_wr_d;
      addr_q  <= addr_d;
      cfg_q   <= cfg_d;
      id_q    <= id_d;
      beats_q <= beats_d;
      bad_q   <= bad_d;
      werr_q  <= werr_d;
      r_ok_q  <= r_ok_d;
      w_ready <= w_ready_d;
      b_valid <= b_valid_d;
      b_resp  <= b_resp_d;
      b_id    <= b_id_d;
      r_valid <= r_valid_d;
      r_resp  <= r_resp_d;
      r_last  <= r_last_d;
      r_id    <= r_id_d;
    end
  end

endmodule

// File: tb/tb_dbg_axi_slave_mem.sv
// Directed bench for dbg_axi_slave_mem: a byte-array memory model predicts every B and R beat.
module tb_dbg_axi_slave_mem;

  localparam int     DEPTH = 2048;
  localparam longint BASE  = 0;
  localparam int     TMO   = 300;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        aw_valid, aw_ready, w_valid, w_ready, w_last, b_valid, b_ready;
  logic        ar_valid, ar_ready, r_valid, r_ready, r_last;
  logic [31:0] aw_addr, ar_addr;
  logic [7:0]  aw_len, ar_len, w_strb;
  logic [2:0]  aw_size, ar_size;
  logic [1:0]  aw_burst, ar_burst, b_resp, r_resp;
  logic [3:0]  aw_id, ar_id, b_id, r_id;
  logic [63:0] w_data, r_data;

  always #5 clk = ~clk;

  dbg_axi_slave_mem dut (
    .clk(clk), .rst_n(rst_n),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_len(aw_len),
    .aw_size(aw_size), .aw_burst(aw_burst), .aw_id(aw_id),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
    .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp), .b_id(b_id),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_len(ar_len),
    .ar_size(ar_size), .ar_burst(ar_burst), .ar_id(ar_id),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp),
    .r_last(r_last), .r_id(r_id)
  );

  typedef struct { logic [63:0] data; logic [1:0] resp; logic last; logic [3:0] id; } rbeat_t;
  typedef struct { logic [1:0] resp; logic [3:0] id; } bexp_t;

  rbeat_t      exp_r[$];
  bexp_t       exp_b[$];
  logic [63:0] rd_log[$];
  byte         glog[$];
  logic [63:0] mem_m [DEPTH];
  logic [63:0] wdat [16];
  logic [7:0]  wstb [16];
  logic        wlst [16];
  logic [1:0]  last_bresp;
  int          n_tests = 0, n_fail = 0, last_ar_wait = 0, cnt;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  task automatic tmo_fail(input string what);
    n_tests++;
    n_fail++;
    $display("FAIL timeout_%s: got no handshake expected one within %0d cycles", what, TMO);
  endtask

  // ---------------- memory model ----------------
  function automatic longint beat_addr(input longint a, input int len, input int size, input int burst, input int i);
    longint sz, tot, base;
    sz  = longint'(1) << size;
    tot = longint'(len + 1) * sz;
    if (burst == 0) return a;
    if (burst == 2) begin
      base = (a / tot) * tot;
      return base + ((a - base) + longint'(i) * sz) % tot;
    end
    return a + longint'(i) * sz;
  endfunction

  function automatic bit legal(input longint a, input int len, input int size, input int burst);
    if (size > 3 || burst == 3) return 1'b0;
    if (burst == 2) begin
`ifdef DBG_AXI_SLAVE_WRAP_EN
      return (len == 1 || len == 3 || len == 7 || len == 15) && (a % (longint'(1) << size) == 0);
`else
      return 1'b0;
`endif
    end
    return 1'b1;
  endfunction

  function automatic bit in_range(input longint a);
    return (a >= BASE) && ((a - BASE) / 8 < longint'(DEPTH));
  endfunction

  function automatic void model_write(input longint addr, input int len, input int size, input int burst, input logic [3:0] id);
    bit err, leg;
    longint a;
    int idx;
    leg = legal(addr, len, size, burst);
    err = !leg;
    for (int i = 0; i <= len; i++) begin
      a = beat_addr(addr, len, size, burst, i);
      if (wlst[i] != (i == len)) err = 1'b1;
      if (!in_range(a)) err = 1'b1;
      else if (leg) begin
        idx = int'((a - BASE) / 8);
        for (int b = 0; b < 8; b++) if (wstb[i][b]) mem_m[idx][b*8 +: 8] = wdat[i][b*8 +: 8];
      end
    end
    exp_b.push_back('{resp: err ? 2'b10 : 2'b00, id: id});
  endfunction

  function automatic void model_read(input longint addr, input int len, input int size, input int burst, input logic [3:0] id);
    bit ok;
    longint a;
    for (int i = 0; i <= len; i++) begin
      a  = beat_addr(addr, len, size, burst, i);
      ok = legal(addr, len, size, burst) && in_range(a);
      exp_r.push_back('{data: ok ? mem_m[int'((a - BASE) / 8)] : 64'd0, resp: ok ? 2'b00 : 2'b10,
                        last: (i == len), id: id});
    end
  endfunction

  function automatic void set_beats(input int len, input logic [63:0] d0, input logic [7:0] s);
    for (int i = 0; i < 16; i++) begin
      wdat[i] = d0 + 64'(i) * 64'h1111_1111_1111_1111;
      wstb[i] = s;
      wlst[i] = (i == len);
    end
  endfunction

  // ---------------- drivers ----------------
  task automatic drive_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                             input logic [1:0] burst, input logic [3:0] id);
    int n;
    aw_addr = addr; aw_len = len; aw_size = size; aw_burst = burst; aw_id = id; aw_valid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!aw_ready && n < TMO);
    if (!aw_ready) tmo_fail("aw");
    @(posedge clk); #1 aw_valid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      w_data = wdat[i]; w_strb = wstb[i]; w_last = wlst[i]; w_valid = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!w_ready && n < TMO);
      if (!w_ready) tmo_fail("w");
      @(posedge clk); #1;
    end
    w_valid = 1'b0; w_last = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!(b_valid && b_ready) && n < TMO);
    if (!(b_valid && b_ready)) tmo_fail("b");
    @(posedge clk); #1;
  endtask

  task automatic drive_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [3:0] id);
    int n;
    ar_addr = addr; ar_len = len; ar_size = size; ar_burst = burst; ar_id = id; ar_valid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!ar_ready && n < TMO);
    if (!ar_ready) tmo_fail("ar");
    last_ar_wait = n;
    @(posedge clk); #1 ar_valid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!(r_valid && r_ready) && n < TMO);
      if (!(r_valid && r_ready)) tmo_fail("r");
      @(posedge clk); #1;
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [3:0] id);
    model_write(longint'(addr), int'(len), int'(size), int'(burst), id);
    drive_write(addr, len, size, burst, id);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [3:0] id);
    model_read(longint'(addr), int'(len), int'(size), int'(burst), id);
    drive_read(addr, len, size, burst, id);
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (aw_ready && ar_ready) chk("dual_grant", 1'b1, 1'b0);
      if (aw_valid && aw_ready) glog.push_back(8'h57);
      if (ar_valid && ar_ready) glog.push_back(8'h52);
      if (b_valid) begin
        if (exp_b.size() == 0) chk("b_unexpected", 64'(b_valid), 64'd0);
        else begin
          chk("b_resp", 64'(b_resp), 64'(exp_b[0].resp));
          chk("b_id", 64'(b_id), 64'(exp_b[0].id));
          if (b_ready) begin last_bresp = b_resp; void'(exp_b.pop_front()); end
        end
      end
      if (r_valid) begin
        if (exp_r.size() == 0) chk("r_unexpected", 64'(r_valid), 64'd0);
        else begin
          chk("r_data", r_data, exp_r[0].data);
          chk("r_resp", 64'(r_resp), 64'(exp_r[0].resp));
          chk("r_last", 64'(r_last), 64'(exp_r[0].last));
          chk("r_id", 64'(r_id), 64'(exp_r[0].id));
          if (r_ready) begin rd_log.push_back(r_data); void'(exp_r.pop_front()); end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b1; aw_valid = 0; w_valid = 0; ar_valid = 0; w_last = 0; b_ready = 1; r_ready = 1;
    aw_addr = 0; aw_len = 0; aw_size = 0; aw_burst = 0; aw_id = 0; w_data = 0; w_strb = 0;
    ar_addr = 0; ar_len = 0; ar_size = 0; ar_burst = 0; ar_id = 0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_aw_ready", 64'(aw_ready), 0); chk("rst_ar_ready", 64'(ar_ready), 0);
    chk("rst_w_ready", 64'(w_ready), 0);   chk("rst_b_valid", 64'(b_valid), 0);
    chk("rst_r_valid", 64'(r_valid), 0);   chk("rst_r_data", r_data, 0);
    chk("rst_r_last", 64'(r_last), 0);     chk("rst_b_resp", 64'(b_resp), 0);
    chk("rst_r_resp", 64'(r_resp), 0);     chk("rst_ids", 64'({b_id, r_id}), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: INCR write/read of four beats
    set_beats(3, 64'h1111_1111_1111_1111, 8'hFF);
    do_write(32'h100, 8'd3, 3'd3, 2'b01, 4'h3);
    chk("t1_bresp_lit", 64'(last_bresp), 64'h0);
    rd_log.delete();
    do_read(32'h100, 8'd3, 3'd3, 2'b01, 4'h9);
    chk("t1_rd0_lit", rd_log[0], 64'h1111_1111_1111_1111);
    chk("t1_rd3_lit", rd_log[3], 64'h4444_4444_4444_4444);

    // 2: byte-lane strobes
    set_beats(0, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    do_write(32'h200, 8'd0, 3'd3, 2'b01, 4'h1);
    set_beats(0, 64'hAAAA_AAAA_BBBB_BBBB, 8'h0F);
    do_write(32'h200, 8'd0, 3'd3, 2'b01, 4'h2);
    chk("t2_model_lit", mem_m[32'h200 >> 3], 64'hFFFF_FFFF_BBBB_BBBB);
    rd_log.delete();
    do_read(32'h200, 8'd0, 3'd3, 2'b01, 4'h4);
    chk("t2_rd_lit", rd_log[0], 64'hFFFF_FFFF_BBBB_BBBB);

    // 3: simultaneous AW/AR twice; write wins first each time
    glog.delete(); rd_log.delete();
    for (int p = 0; p < 2; p++) begin
      set_beats(0, (p == 0) ? 64'h5555_5555_5555_5555 : 64'h6666_6666_6666_6666, 8'hFF);
      model_write(longint'(32'h300 + 8 * p), 0, 3, 1, 4'hA);
      model_read(longint'(32'h300 + 8 * p), 0, 3, 1, 4'hB);
      fork
        drive_write(32'h300 + 32'(8 * p), 8'd0, 3'd3, 2'b01, 4'hA);
        drive_read(32'h300 + 32'(8 * p), 8'd0, 3'd3, 2'b01, 4'hB);
      join
    end
    chk("t3_grant_cnt", 64'(glog.size()), 4);
    chk("t3_grant_order", {glog[0], glog[1], glog[2], glog[3]}, 64'h5752_5752);
    chk("t3_rd1_lit", rd_log[1], 64'h6666_6666_6666_6666);

    // 4: burst running off the end of the RAM
    set_beats(3, 64'h7777_7777_7777_7777, 8'hFF);
    do_write(32'(8 * (DEPTH - 1)), 8'd3, 3'd3, 2'b01, 4'h5);
    chk("t4_bresp_lit", 64'(last_bresp), 64'h2);
    rd_log.delete();
    do_read(32'(8 * (DEPTH - 1)), 8'd3, 3'd3, 2'b01, 4'h6);
    chk("t4_rd0_lit", rd_log[0], 64'h7777_7777_7777_7777);
    chk("t4_rd1_lit", rd_log[1], 64'h0);

    // misc: FIXED burst, oversize beat, reserved burst type
    set_beats(2, 64'h0101_0101_0101_0101, 8'hFF);
    wstb[1] = 8'hF0; wstb[2] = 8'h01;
    do_write(32'h400, 8'd2, 3'd3, 2'b00, 4'h7);
    do_read(32'h400, 8'd1, 3'd3, 2'b00, 4'h7);
    set_beats(0, 64'hDEAD_BEEF_0000_0000, 8'hFF);
    do_write(32'h500, 8'd0, 3'd4, 2'b01, 4'h8);
    do_read(32'h100, 8'd1, 3'd3, 2'b11, 4'h8);

    // 5: early w_last, back-pressure on B and R, reset in the middle of a read
    set_beats(1, 64'h9999_9999_9999_9999, 8'hFF);
    wlst[0] = 1'b1; wlst[1] = 1'b0;
    model_write(longint'(32'h600), 1, 3, 1, 4'hC);
    b_ready = 1'b0; cnt = 0;
    fork
      drive_write(32'h600, 8'd1, 3'd3, 2'b01, 4'hC);
      begin
        for (int n = 0; n < TMO && !b_valid; n++) @(negedge clk);
        repeat (10) begin @(negedge clk); if (b_valid) cnt++; end
        b_ready = 1'b1;
      end
    join
    chk("t5_bresp_lit", 64'(last_bresp), 64'h2);
    chk("t5_b_hold", 64'(cnt), 64'd10);
    r_ready = 1'b0; cnt = 0;
    model_read(longint'(32'h100), 1, 3, 1, 4'hD);
    ar_addr = 32'h100; ar_len = 8'd1; ar_size = 3'd3; ar_burst = 2'b01; ar_id = 4'hD; ar_valid = 1'b1;
    for (int n = 0; n < TMO && !ar_ready; n++) @(negedge clk);
    @(posedge clk); #1 ar_valid = 1'b0;
    for (int n = 0; n < TMO && !r_valid; n++) @(negedge clk);
    repeat (10) begin @(negedge clk); if (r_valid) cnt++; end
    chk("t5_r_hold", 64'(cnt), 64'd10);
    @(posedge clk); #1 rst_n = 1'b0;
    exp_r.delete();
    @(negedge clk);
    chk("t5_rst_r_valid", 64'(r_valid), 0);
    chk("t5_rst_b_valid", 64'(b_valid), 0);
    @(posedge clk); #1 rst_n = 1'b1; r_ready = 1'b1;
    do_read(32'h108, 8'd0, 3'd3, 2'b01, 4'hE);
    chk("t5_idle_after_rst", 64'(last_ar_wait), 64'd1);

    // 6: WRAP write of four beats starting at 0x118, then INCR readback of the window
    set_beats(3, 64'hD0D0_D0D0_D0D0_D0D0, 8'hFF);
    do_write(32'h118, 8'd3, 3'd3, 2'b10, 4'hF);
    rd_log.delete();
    do_read(32'h100, 8'd3, 3'd3, 2'b01, 4'hF);
`ifdef DBG_AXI_SLAVE_WRAP_EN
    chk("t6_bresp_lit", 64'(last_bresp), 64'h0);
    chk("t6_rd0_lit", rd_log[0], 64'hE1E1_E1E1_E1E1_E1E1);
    chk("t6_rd3_lit", rd_log[3], 64'hD0D0_D0D0_D0D0_D0D0);
`else
    chk("t6_bresp_lit", 64'(last_bresp), 64'h2);
    chk("t6_rd0_lit", rd_log[0], 64'h1111_1111_1111_1111);
    chk("t6_rd3_lit", rd_log[3], 64'h4444_4444_4444_4444);
`endif
    do_read(32'h118, 8'd3, 3'd3, 2'b10, 4'h2);

    repeat (3) @(negedge clk);
    chk("exp_b_drained", 64'(exp_b.size()), 0);
    chk("exp_r_drained", 64'(exp_r.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no end of test expected one within 2 ms");
    $fatal(1, "global timeout");
  end

endmodule
